// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, op encodings, bit indices and cause codes shared by the CSR unit
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS    = 12'h300;
   localparam logic [11:0] CSR_MISA       = 12'h301;
   localparam logic [11:0] CSR_MIE        = 12'h304;
   localparam logic [11:0] CSR_MTVEC      = 12'h305;
   localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
   localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
   localparam logic [11:0] CSR_MEPC       = 12'h341;
   localparam logic [11:0] CSR_MCAUSE     = 12'h342;
   localparam logic [11:0] CSR_MTVAL      = 12'h343;
   localparam logic [11:0] CSR_MIP        = 12'h344;
   localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
   localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
   localparam logic [11:0] CSR_MARCHID    = 12'hF12;
   localparam logic [11:0] CSR_MIMPID     = 12'hF13;
   localparam logic [11:0] CSR_MHARTID    = 12'hF14;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam int MIP_MSIP = 3;
   localparam int MIP_MTIP = 7;
   localparam int MIP_MEIP = 11;

   localparam logic [4:0] CAUSE_ILLEGAL_INSN = 5'd2;
   localparam logic [4:0] CAUSE_IRQ_SW       = 5'd3;
   localparam logic [4:0] CAUSE_IRQ_TIMER    = 5'd7;
   localparam logic [4:0] CAUSE_IRQ_EXT      = 5'd11;

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit free-running counter with per-half write port
module csr_counter64 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   input  logic        wr_lo_i,
   input  logic        wr_hi_i,
   input  logic [31:0] wdata_lo_i,
   input  logic [31:0] wdata_hi_i,
   output logic [63:0] cnt_o
);

   // A write to either half suppresses the increment for that cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_o <= '0;
      end else if (wr_lo_i || wr_hi_i) begin
         if (wr_lo_i) cnt_o[31:0]  <= wdata_lo_i;
         if (wr_hi_i) cnt_o[63:32] <= wdata_hi_i;
      end else if (inc_i) begin
         cnt_o <= cnt_o + 64'd1;
      end
   end

endmodule

// File: rtl/csr_file_m.sv
// rtl/csr_file_m.sv - machine-mode CSR unit: CSR access, counters, trap entry and mret
module csr_file_m
   import csr_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int unsigned     HART_ID     = 0,
   parameter logic [XLEN-1:0] MISA_VAL    = 'h4000_0100,
   parameter bit              VECTORED_EN = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            csr_valid_i,
   input  logic [1:0]      csr_op_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            csr_rvalid_o,
   output logic            csr_illegal_o,
   input  logic            instret_i,
   input  logic            irq_sw_i,
   input  logic            irq_timer_i,
   input  logic            irq_ext_i,
   input  logic            trap_i,
   input  logic            trap_intr_i,
   input  logic [4:0]      trap_cause_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic [XLEN-1:0] trap_tval_i,
   input  logic            mret_i,
   output logic [XLEN-1:0] trap_vector_o,
   output logic [XLEN-1:0] mepc_o,
   output logic            irq_pending_o
);

   localparam logic [XLEN-1:0] MTVEC_MASK  = VECTORED_EN ? ~XLEN'(2) : ~XLEN'(3);
   localparam logic [XLEN-1:0] MEPC_MASK   = ~XLEN'(3);
   localparam logic [XLEN-1:0] MCAUSE_MASK = {1'b1, {(XLEN-6){1'b0}}, 5'h1F};

   logic            mie_bit_q, mpie_bit_q;
   logic [2:0]      mie_q;
   logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mcounteren_q;
   logic [63:0]     mcycle, minstret;

   logic [XLEN-1:0] mstatus_v, mie_v, mip_v, rd_val, wr_val;
   logic [63:0]     wval64;
   logic            impl, read_only, access, wr_req, illegal, wr_en;

   always_comb begin
      mstatus_v = '0;
      mstatus_v[MSTATUS_MIE]  = mie_bit_q;
      mstatus_v[MSTATUS_MPIE] = mpie_bit_q;
      mstatus_v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      mie_v = '0;
      mie_v[MIP_MSIP] = mie_q[0];
      mie_v[MIP_MTIP] = mie_q[1];
      mie_v[MIP_MEIP] = mie_q[2];
      mip_v = '0;
      mip_v[MIP_MSIP] = irq_sw_i;
      mip_v[MIP_MTIP] = irq_timer_i;
      mip_v[MIP_MEIP] = irq_ext_i;
   end

   always_comb begin
      rd_val    = '0;
      impl      = 1'b1;
      read_only = 1'b0;
      case (csr_addr_i)
         CSR_MISA:       begin rd_val = MISA_VAL; read_only = 1'b1; end
         CSR_MVENDORID,
         CSR_MARCHID,
         CSR_MIMPID:     read_only = 1'b1;
         CSR_MHARTID:    begin rd_val = XLEN'(HART_ID); read_only = 1'b1; end
         CSR_MSTATUS:    rd_val = mstatus_v;
         CSR_MIE:        rd_val = mie_v;
         CSR_MTVEC:      rd_val = mtvec_q;
         CSR_MCOUNTEREN: rd_val = mcounteren_q;
         CSR_MSCRATCH:   rd_val = mscratch_q;
         CSR_MEPC:       rd_val = mepc_q;
         CSR_MCAUSE:     rd_val = mcause_q;
         CSR_MTVAL:      rd_val = mtval_q;
         CSR_MIP:        begin rd_val = mip_v; read_only = 1'b1; end
         CSR_MCYCLE:     rd_val = mcycle[XLEN-1:0];
         CSR_MINSTRET:   rd_val = minstret[XLEN-1:0];
         CSR_MCYCLEH:    if (XLEN == 32) rd_val = XLEN'(mcycle[63:32]);   else impl = 1'b0;
         CSR_MINSTRETH:  if (XLEN == 32) rd_val = XLEN'(minstret[63:32]); else impl = 1'b0;
         default:        impl = 1'b0;
      endcase
   end

   always_comb begin
      case (csr_op_i)
         CSR_RW:  wr_val = csr_wdata_i;
         CSR_RS:  wr_val = rd_val | csr_wdata_i;
         CSR_RC:  wr_val = rd_val & ~csr_wdata_i;
         default: wr_val = rd_val;
      endcase
   end

   // Trap entry and mret own the cycle; a colliding CSR write is dropped entirely.
   assign access  = csr_valid_i && (csr_op_i != CSR_NONE);
   assign wr_req  = (csr_op_i == CSR_RW) || (csr_wdata_i != '0);
   assign illegal = access && (!impl || (read_only && wr_req));
   assign wr_en   = access && wr_req && !illegal && !trap_i && !mret_i;
   assign wval64  = 64'(wr_val);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mie_bit_q    <= 1'b0;
         mpie_bit_q   <= 1'b0;
         mie_q        <= '0;
         mtvec_q      <= '0;
         mscratch_q   <= '0;
         mepc_q       <= '0;
         mcause_q     <= '0;
         mtval_q      <= '0;
         mcounteren_q <= '0;
      end else if (trap_i) begin
         mepc_q     <= trap_pc_i & MEPC_MASK;
         mcause_q   <= {trap_intr_i, {(XLEN-6){1'b0}}, trap_cause_i};
         mtval_q    <= trap_tval_i;
         mpie_bit_q <= mie_bit_q;
         mie_bit_q  <= 1'b0;
      end else if (mret_i) begin
         mie_bit_q  <= mpie_bit_q;
         mpie_bit_q <= 1'b1;
      end else if (wr_en) begin
         case (csr_addr_i)
            CSR_MSTATUS: begin
               mie_bit_q  <= wr_val[MSTATUS_MIE];
               mpie_bit_q <= wr_val[MSTATUS_MPIE];
            end
            CSR_MIE:        mie_q <= {wr_val[MIP_MEIP], wr_val[MIP_MTIP], wr_val[MIP_MSIP]};
            CSR_MTVEC:      mtvec_q      <= wr_val & MTVEC_MASK;
            CSR_MCOUNTEREN: mcounteren_q <= wr_val;
            CSR_MSCRATCH:   mscratch_q   <= wr_val;
            CSR_MEPC:       mepc_q       <= wr_val & MEPC_MASK;
            CSR_MCAUSE:     mcause_q     <= wr_val & MCAUSE_MASK;
            CSR_MTVAL:      mtval_q      <= wr_val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         csr_rdata_o   <= '0;
         csr_rvalid_o  <= 1'b0;
         csr_illegal_o <= 1'b0;
      end else begin
         csr_rdata_o   <= (access && !illegal) ? rd_val : '0;
         csr_rvalid_o  <= access;
         csr_illegal_o <= illegal;
      end
   end

   // Upper-half writes (mcycleh/minstreth) carry their data in the low word of the operand.
   csr_counter64 u_mcycle (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (1'b1),
      .wr_lo_i    (wr_en && (csr_addr_i == CSR_MCYCLE)),
      .wr_hi_i    (wr_en && ((csr_addr_i == CSR_MCYCLEH) || ((XLEN == 64) && (csr_addr_i == CSR_MCYCLE)))),
      .wdata_lo_i (wval64[31:0]),
      .wdata_hi_i (csr_addr_i[7] ? wval64[31:0] : wval64[63:32]),
      .cnt_o      (mcycle)
   );

   csr_counter64 u_minstret (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (instret_i),
      .wr_lo_i    (wr_en && (csr_addr_i == CSR_MINSTRET)),
      .wr_hi_i    (wr_en && ((csr_addr_i == CSR_MINSTRETH) || ((XLEN == 64) && (csr_addr_i == CSR_MINSTRET)))),
      .wdata_lo_i (wval64[31:0]),
      .wdata_hi_i (csr_addr_i[7] ? wval64[31:0] : wval64[63:32]),
      .cnt_o      (minstret)
   );

   assign trap_vector_o = {mtvec_q[XLEN-1:2], 2'b00} +
                          ((mtvec_q[0] && trap_intr_i) ? XLEN'({trap_cause_i, 2'b00}) : '0);
   assign mepc_o        = mepc_q;
   assign irq_pending_o = mie_bit_q && |(mip_v & mie_v);

endmodule

// File: tb/tb_csr_file_m.sv
// tb/tb_csr_file_m.sv - self-checking bench for csr_file_m (RV32 vectored and RV64 direct-only instances)
module tb_csr_file_m;

   logic        clk, rst, csr_valid, instret, irq_sw, irq_timer, irq_ext;
   logic        trap, trap_intr, mret;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] wdata, trap_pc, trap_tval;
   logic [4:0]  trap_cause;

   logic [31:0] rdata32, vec32, mepc32;
   logic        rvalid32, ill32, pend32;
   logic [63:0] rdata64, vec64, mepc64, wdata64, trap_pc64, trap_tval64;
   logic        rvalid64, ill64, pend64;

   int checks = 0;
   int errors = 0;

   assign wdata64     = {32'h0, wdata};
   assign trap_pc64   = {32'h0, trap_pc};
   assign trap_tval64 = {32'h0, trap_tval};

   csr_file_m #(.XLEN(32), .HART_ID(3), .MISA_VAL(32'h4000_0100), .VECTORED_EN(1'b1)) u_dut (
      .clk_i(clk), .rst_i(rst), .csr_valid_i(csr_valid), .csr_op_i(csr_op),
      .csr_addr_i(csr_addr), .csr_wdata_i(wdata), .csr_rdata_o(rdata32),
      .csr_rvalid_o(rvalid32), .csr_illegal_o(ill32), .instret_i(instret),
      .irq_sw_i(irq_sw), .irq_timer_i(irq_timer), .irq_ext_i(irq_ext),
      .trap_i(trap), .trap_intr_i(trap_intr), .trap_cause_i(trap_cause),
      .trap_pc_i(trap_pc), .trap_tval_i(trap_tval), .mret_i(mret),
      .trap_vector_o(vec32), .mepc_o(mepc32), .irq_pending_o(pend32)
   );

   csr_file_m #(.XLEN(64), .HART_ID(3), .MISA_VAL(64'h4000_0100), .VECTORED_EN(1'b0)) u_dut64 (
      .clk_i(clk), .rst_i(rst), .csr_valid_i(csr_valid), .csr_op_i(csr_op),
      .csr_addr_i(csr_addr), .csr_wdata_i(wdata64), .csr_rdata_o(rdata64),
      .csr_rvalid_o(rvalid64), .csr_illegal_o(ill64), .instret_i(instret),
      .irq_sw_i(irq_sw), .irq_timer_i(irq_timer), .irq_ext_i(irq_ext),
      .trap_i(trap), .trap_intr_i(trap_intr), .trap_cause_i(trap_cause),
      .trap_pc_i(trap_pc64), .trap_tval_i(trap_tval64), .mret_i(mret),
      .trap_vector_o(vec64), .mepc_o(mepc64), .irq_pending_o(pend64)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_ill;
   } vec_t;

   vec_t vecs [0:32];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One access per call; consecutive calls issue back-to-back requests.
   task automatic access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
      @(negedge clk);
      csr_valid = 1'b1;
      csr_op    = op;
      csr_addr  = addr;
      wdata     = wd;
      @(posedge clk);
      #1;
      csr_valid = 1'b0;
      csr_op    = 2'b00;
   endtask

   task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
      access(2'b10, addr, 32'h0);
      chk(name, {32'h0, rdata32}, {32'h0, exp});
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{2'b10, 12'hF14, 32'h0,         32'h3,         1'b0};
      vecs[1]  = '{2'b01, 12'hF14, 32'h5,         32'h0,         1'b1};
      vecs[2]  = '{2'b10, 12'hF14, 32'h0,         32'h3,         1'b0};
      vecs[3]  = '{2'b10, 12'h301, 32'h0,         32'h4000_0100, 1'b0};
      vecs[4]  = '{2'b01, 12'h301, 32'h0,         32'h0,         1'b1};
      vecs[5]  = '{2'b10, 12'h300, 32'h0,         32'h0000_1800, 1'b0};
      vecs[6]  = '{2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0};
      vecs[7]  = '{2'b10, 12'h300, 32'h0,         32'h0000_1888, 1'b0};
      vecs[8]  = '{2'b11, 12'h300, 32'h8,         32'h0000_1888, 1'b0};
      vecs[9]  = '{2'b10, 12'h300, 32'h0,         32'h0000_1880, 1'b0};
      vecs[10] = '{2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0,         1'b0};
      vecs[11] = '{2'b10, 12'h304, 32'h0,         32'h0000_0888, 1'b0};
      vecs[12] = '{2'b01, 12'h305, 32'hFFFF_FFFF, 32'h0,         1'b0};
      vecs[13] = '{2'b01, 12'h305, 32'h8000_0001, 32'hFFFF_FFFD, 1'b0};
      vecs[14] = '{2'b10, 12'h305, 32'h0,         32'h8000_0001, 1'b0};
      vecs[15] = '{2'b01, 12'h341, 32'h123,       32'h0,         1'b0};
      vecs[16] = '{2'b10, 12'h341, 32'h0,         32'h120,       1'b0};
      vecs[17] = '{2'b01, 12'h342, 32'hFFFF_FFFF, 32'h0,         1'b0};
      vecs[18] = '{2'b11, 12'h342, 32'h1F,        32'h8000_001F, 1'b0};
      vecs[19] = '{2'b10, 12'h342, 32'h0,         32'h8000_0000, 1'b0};
      vecs[20] = '{2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[21] = '{2'b11, 12'h340, 32'hFFFF_0000, 32'hDEAD_BEEF, 1'b0};
      vecs[22] = '{2'b10, 12'h340, 32'h0,         32'h0000_BEEF, 1'b0};
      vecs[23] = '{2'b01, 12'h7C0, 32'h1,         32'h0,         1'b1};
      vecs[24] = '{2'b10, 12'h344, 32'h0,         32'h0,         1'b0};
      vecs[25] = '{2'b10, 12'h344, 32'h8,         32'h0,         1'b1};
      vecs[26] = '{2'b01, 12'h343, 32'h55,        32'h0,         1'b0};
      vecs[27] = '{2'b10, 12'h343, 32'h0,         32'h55,        1'b0};
      vecs[28] = '{2'b01, 12'h306, 32'h7,         32'h0,         1'b0};
      vecs[29] = '{2'b10, 12'h306, 32'h0,         32'h7,         1'b0};
      vecs[30] = '{2'b10, 12'hF11, 32'h0,         32'h0,         1'b0};
      vecs[31] = '{2'b10, 12'hB02, 32'h0,         32'h0,         1'b0};
      vecs[32] = '{2'b10, 12'hB82, 32'h0,         32'h0,         1'b0};

      clk = 1'b0; rst = 1'b1; csr_valid = 1'b0; csr_op = 2'b00; csr_addr = '0; wdata = '0;
      instret = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
      trap = 1'b0; trap_intr = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0; mret = 1'b0;

      repeat (2) @(negedge clk);
      chk("reset rdata",   {32'h0, rdata32}, 64'h0);
      chk("reset rvalid",  {63'h0, rvalid32}, 64'h0);
      chk("reset illegal", {63'h0, ill32}, 64'h0);
      chk("reset vector",  {32'h0, vec32}, 64'h0);
      chk("reset mepc",    {32'h0, mepc32}, 64'h0);
      chk("reset pending", {63'h0, pend32}, 64'h0);
      chk("reset 64 outs", {rdata64[31:0], mepc64[31:0]} | {63'h0, rvalid64 | pend64}, 64'h0);
      rst = 1'b0;

      for (int i = 0; i <= 32; i++) begin
         access(vecs[i].op, vecs[i].addr, vecs[i].wd);
         chk($sformatf("vec%0d rdata", i), {32'h0, rdata32}, {32'h0, vecs[i].exp_rd});
         chk($sformatf("vec%0d illegal", i), {63'h0, ill32}, {63'h0, vecs[i].exp_ill});
         chk($sformatf("vec%0d rvalid", i), {63'h0, rvalid32}, 64'h1);
      end

      // Trap vector: mtvec = 0x8000_0001 (vectored) on RV32, forced direct on RV64.
      access(2'b10, 12'h300, 32'h8);
      chk("set MIE old", {32'h0, rdata32}, 64'h1880);
      trap_intr = 1'b1; trap_cause = 5'd7; #1;
      chk("vectored target",   {32'h0, vec32}, 64'h8000_001C);
      chk("direct-only target", vec64, 64'h8000_0000);
      trap_intr = 1'b0; #1;
      chk("exception target", {32'h0, vec32}, 64'h8000_0000);

      // Trap entry with MIE=1.
      trap = 1'b1; trap_cause = 5'd2; trap_pc = 32'h100; trap_tval = 32'hBAD;
      @(posedge clk); #1;
      trap = 1'b0;
      chk("trap mepc", {32'h0, mepc32}, 64'h100);
      rd_chk("trap mcause", 12'h342, 32'h2);
      rd_chk("trap mstatus", 12'h300, 32'h1880);
      rd_chk("trap mtval", 12'h343, 32'hBAD);

      // mret restores MIE from MPIE and sets MPIE.
      @(negedge clk); mret = 1'b1;
      @(posedge clk); #1; mret = 1'b0;
      rd_chk("mret mstatus", 12'h300, 32'h1888);
      access(2'b11, 12'h300, 32'h80);
      chk("clear MPIE old", {32'h0, rdata32}, 64'h1888);
      @(negedge clk); mret = 1'b1;
      @(posedge clk); #1; mret = 1'b0;
      rd_chk("mret MPIE=0", 12'h300, 32'h1880);

      // Interrupt pending path.
      irq_timer = 1'b1; #1;
      chk("pending MIE=0", {63'h0, pend32}, 64'h0);
      access(2'b10, 12'h304, 32'h80);
      chk("RS mie old", {32'h0, rdata32}, 64'h888);
      access(2'b11, 12'h300, 32'h0);
      chk("RC0 mstatus read", {32'h0, rdata32}, 64'h1880);
      chk("pending after pure read", {63'h0, pend32}, 64'h0);
      access(2'b10, 12'h300, 32'h8);
      chk("pending after MIE set", {63'h0, pend32}, 64'h1);
      rd_chk("mip timer", 12'h344, 32'h80);
      irq_timer = 1'b0; #1;
      chk("pending timer off", {63'h0, pend32}, 64'h0);
      irq_ext = 1'b1; #1;
      chk("pending ext", {63'h0, pend32}, 64'h1);
      irq_ext = 1'b0;

      // CSR write colliding with trap entry is discarded; read returns old value.
      trap = 1'b1; trap_intr = 1'b1; trap_cause = 5'd11; trap_pc = 32'h300; trap_tval = 32'h0;
      access(2'b01, 12'h341, 32'h200);
      trap = 1'b0; trap_intr = 1'b0;
      chk("collide read old", {32'h0, rdata32}, 64'h100);
      chk("collide mepc", {32'h0, mepc32}, 64'h300);
      rd_chk("irq mcause", 12'h342, 32'h8000_000B);
      rd_chk("irq trap mstatus", 12'h300, 32'h1880);

      // CSR write colliding with mret is discarded.
      mret = 1'b1;
      access(2'b01, 12'h340, 32'h1234);
      mret = 1'b0;
      chk("mret collide read", {32'h0, rdata32}, 64'hBEEF);
      rd_chk("mret collide mscratch", 12'h340, 32'hBEEF);
      rd_chk("mret collide mstatus", 12'h300, 32'h1888);

      // mcycle low-half write then carry into mcycleh.
      access(2'b01, 12'hB00, 32'hFFFF_FFFF);
      chk("mcycle write legal", {63'h0, ill32}, 64'h0);
      rd_chk("mcycle written", 12'hB00, 32'hFFFF_FFFF);
      rd_chk("mcycle wrapped", 12'hB00, 32'h0);
      access(2'b10, 12'hB80, 32'h0);
      chk("mcycleh carry", {32'h0, rdata32}, 64'h1);
      chk("mcycleh legal rv32", {63'h0, ill32}, 64'h0);
      chk("mcycleh illegal rv64", {63'h0, ill64}, 64'h1);

      // minstret write drops the same-cycle increment.
      instret = 1'b1;
      access(2'b01, 12'hB02, 32'd10);
      rd_chk("minstret written", 12'hB02, 32'd10);
      instret = 1'b0;
      rd_chk("minstret incremented", 12'hB02, 32'd11);

      @(posedge clk); #1;
      chk("rvalid pulse", {63'h0, rvalid32}, 64'h0);

      // Reset during an access cancels its response.
      @(negedge clk);
      csr_valid = 1'b1; csr_op = 2'b10; csr_addr = 12'hF14; wdata = 32'h0;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      csr_valid = 1'b0; csr_op = 2'b00;
      chk("reset cancels rvalid", {63'h0, rvalid32}, 64'h0);
      chk("reset cancels rdata", {32'h0, rdata32}, 64'h0);
      @(negedge clk); rst = 1'b0;
      chk("post-reset mepc", {32'h0, mepc32}, 64'h0);
      rd_chk("post-reset mstatus", 12'h300, 32'h1800);
      rd_chk("post-reset mtvec", 12'h305, 32'h0);
      rd_chk("post-reset mscratch", 12'h340, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
